// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types and constants for the memory read arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Bit positions inside the one-hot grant vector
  localparam int unsigned GNT_I = 0;
  localparam int unsigned GNT_D = 1;

endpackage

`default_nettype wire

// File: rtl/arb_sel.sv
// ============================================================================
// Module : arb_sel
// Brief  : Two-way grant selector; i_prio_d picks the data side on a tie.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_sel
  import mem_pkg::*;
(
  input  logic       i_req_i,
  input  logic       i_req_d,
  input  logic       i_prio_d,
  output logic [1:0] o_gnt
);

  logic w_gnt_d;

  assign w_gnt_d      = i_req_d & (i_prio_d | ~i_req_i);
  assign o_gnt[GNT_D] = w_gnt_d;
  assign o_gnt[GNT_I] = i_req_i & ~w_gnt_d;

endmodule

`default_nettype wire

// File: rtl/mem_read_arb.sv
// ============================================================================
// Module : mem_read_arb
// Brief  : Arbitrates instruction/data read requests onto one memory port.
//          Define MEM_READ_ARB_RR_EN for round-robin tie-break (else D > I).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_read_arb
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_re,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_data,
  input  logic            d_re,
  input  logic [XLEN-1:0] d_addr,
  output logic            d_ack,
  output logic [XLEN-1:0] d_data,
  output logic            m_re,
  output logic [XLEN-1:0] m_addr,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_data
);

  state_t          r_state;
  logic            r_m_re;
  logic [XLEN-1:0] r_m_addr;
  logic            w_prio_d;
  logic [1:0]      w_gnt;

  arb_sel u_arb_sel (
    .i_req_i  (i_re),
    .i_req_d  (d_re),
    .i_prio_d (w_prio_d),
    .o_gnt    (w_gnt)
  );

`ifdef MEM_READ_ARB_RR_EN
  logic r_prio_d;

  // After each grant the other side is favoured on the next tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio_d <= 1'b1;
    end else if (r_state == IDLE && (|w_gnt)) begin
      r_prio_d <= w_gnt[GNT_I];
    end
  end

  assign w_prio_d = r_prio_d;
`else
  assign w_prio_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_m_re   <= 1'b0;
      r_m_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt[GNT_D]) begin
            r_state  <= BUSY_D;
            r_m_re   <= 1'b1;
            r_m_addr <= d_addr;
          end else if (w_gnt[GNT_I]) begin
            r_state  <= BUSY_I;
            r_m_re   <= 1'b1;
            r_m_addr <= i_addr;
          end
        end
        BUSY_I, BUSY_D: begin
          // Returning to IDLE forces one idle cycle before the next grant
          if (m_ack) begin
            r_state <= IDLE;
            r_m_re  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_m_re  <= 1'b0;
        end
      endcase
    end
  end

  assign m_re   = r_m_re;
  assign m_addr = r_m_addr;

  // A requester that withdrew keeps the read running but gets no ack
  assign i_ack  = (r_state == BUSY_I) & m_ack & i_re;
  assign d_ack  = (r_state == BUSY_D) & m_ack & d_re;
  assign i_data = i_ack ? m_data : '0;
  assign d_data = d_ack ? m_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_read_arb.sv
// ============================================================================
// Module : tb_mem_read_arb
// Brief  : Self-checking bench for mem_read_arb (honours MEM_READ_ARB_RR_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_read_arb;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_re    = 1'b0;
  logic [31:0] i_addr  = '0;
  logic        d_re    = 1'b0;
  logic [31:0] d_addr  = '0;
  logic        m_ack   = 1'b0;
  logic [31:0] m_data  = '0;
  logic        i_ack, d_ack, m_re;
  logic [31:0] i_data, d_data, m_addr;

  mem_read_arb #(.XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_re    (i_re),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_data  (i_data),
    .d_re    (d_re),
    .d_addr  (d_addr),
    .d_ack   (d_ack),
    .d_data  (d_data),
    .m_re    (m_re),
    .m_addr  (m_addr),
    .m_ack   (m_ack),
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic        cap_i_ack, cap_d_ack;
  logic [31:0] cap_i_data, cap_d_data, cap_addr;
  int          wait_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding read, owner side and its address
  bit          mdl_busy   = 1'b0;
  bit          mdl_side_d = 1'b0;
  logic [31:0] mdl_addr   = '0;
  bit          mdl_last_d = 1'b0;

  function automatic bit pick_data(input bit ri, input bit rd, input bit last_d);
    if (ri && rd) begin
`ifdef MEM_READ_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return rd;
  endfunction

  task automatic mdl_clear();
    mdl_busy   = 1'b0;
    mdl_side_d = 1'b0;
    mdl_addr   = '0;
    mdl_last_d = 1'b0;
  endtask

  initial begin
    logic exp_i_ack, exp_d_ack;
    forever begin
      @(negedge clk);
      if (!reset_n) mdl_clear();
      if (mon_en) begin
        exp_i_ack = mdl_busy && !mdl_side_d && m_ack && i_re;
        exp_d_ack = mdl_busy &&  mdl_side_d && m_ack && d_re;
        chk("cyc_m_re",   {31'd0, m_re},  {31'd0, mdl_busy});
        chk("cyc_m_addr", m_addr,         mdl_addr);
        chk("cyc_i_ack",  {31'd0, i_ack}, {31'd0, exp_i_ack});
        chk("cyc_d_ack",  {31'd0, d_ack}, {31'd0, exp_d_ack});
        chk("cyc_i_data", i_data,         exp_i_ack ? m_data : 32'd0);
        chk("cyc_d_data", d_data,         exp_d_ack ? m_data : 32'd0);
      end
      @(posedge clk);
      if (!reset_n) begin
        mdl_clear();
      end else if (mdl_busy) begin
        if (m_ack) mdl_busy = 1'b0;
      end else if (i_re || d_re) begin
        mdl_side_d = pick_data(i_re, d_re, mdl_last_d);
        mdl_last_d = mdl_side_d;
        mdl_addr   = mdl_side_d ? d_addr : i_addr;
        mdl_busy   = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Memory responder: wait for m_re, optionally perturb requester, ack after lat cycles
  task automatic serve(input int lat, input logic [31:0] data, input bit drop,
                       input bit chg, input logic [31:0] new_addr);
    wait_cyc = 0;
    cap_i_ack = 1'b0; cap_d_ack = 1'b0;
    cap_i_data = '0; cap_d_data = '0; cap_addr = '0;
    while (m_re !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    if (m_re !== 1'b1) begin
      chk("m_re_timeout", {31'd0, m_re}, 32'd1);
      return;
    end
    if (drop) begin
      i_re = 1'b0;
      d_re = 1'b0;
    end
    if (chg) begin
      i_addr = new_addr;
      d_addr = new_addr;
    end
    repeat (lat) tick();
    m_ack  = 1'b1;
    m_data = data;
    #1;
    cap_i_ack  = i_ack;
    cap_d_ack  = d_ack;
    cap_i_data = i_data;
    cap_d_data = d_data;
    cap_addr   = m_addr;
    tick();
    m_ack  = 1'b0;
    m_data = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_sides [4];
    tick();
    tick();
    chk("rst_m_re",   {31'd0, m_re},  32'd0);
    chk("rst_m_addr", m_addr,         32'd0);
    chk("rst_i_ack",  {31'd0, i_ack}, 32'd0);
    chk("rst_d_ack",  {31'd0, d_ack}, 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Single instruction read, memory answers 3 cycles after m_re
    i_addr = 32'h100;
    i_re   = 1'b1;
    serve(3, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
    chk("t1_latency", wait_cyc,                1);
    chk("t1_m_addr",  cap_addr,                32'h100);
    chk("t1_i_ack",   {31'd0, cap_i_ack},      32'd1);
    chk("t1_i_data",  cap_i_data,              32'hDEADBEEF);
    chk("t1_d_ack",   {31'd0, cap_d_ack},      32'd0);
    i_re = 1'b0;
    tick();

    // Simultaneous requests: data side wins first in both builds
    do_reset();
    i_addr = 32'h200;
    d_addr = 32'h300;
    i_re = 1'b1;
    d_re = 1'b1;
    serve(2, 32'h3333_0300, 1'b0, 1'b0, 32'd0);
    chk("t2a_m_addr", cap_addr,           32'h300);
    chk("t2a_d_ack",  {31'd0, cap_d_ack}, 32'd1);
    chk("t2a_i_ack",  {31'd0, cap_i_ack}, 32'd0);
    chk("t2a_d_data", cap_d_data,         32'h3333_0300);
    d_re = 1'b0;
    serve(2, 32'h2222_0200, 1'b0, 1'b0, 32'd0);
    chk("t2b_m_addr", cap_addr,           32'h200);
    chk("t2b_i_ack",  {31'd0, cap_i_ack}, 32'd1);
    chk("t2b_d_ack",  {31'd0, cap_d_ack}, 32'd0);
    chk("t2b_i_data", cap_i_data,         32'h2222_0200);
    i_re = 1'b0;
    tick();

    // Both held for four transactions
    do_reset();
`ifdef MEM_READ_ARB_RR_EN
    exp_sides = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_sides = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    i_addr = 32'h10;
    d_addr = 32'h20;
    i_re = 1'b1;
    d_re = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve(1, 32'hA000_0000 + k, 1'b0, 1'b0, 32'd0);
      chk("t3_side_d", {31'd0, cap_d_ack}, {31'd0, exp_sides[k]});
      chk("t3_side_i", {31'd0, cap_i_ack}, {31'd0, !exp_sides[k]});
      chk("t3_m_addr", cap_addr, exp_sides[k] ? 32'h20 : 32'h10);
    end
    i_re = 1'b0;
    d_re = 1'b0;
    tick();

    // Data requester withdraws after grant
    do_reset();
    d_addr = 32'h400;
    d_re   = 1'b1;
    serve(2, 32'hBAD0_0400, 1'b1, 1'b0, 32'd0);
    chk("t4_d_ack",  {31'd0, cap_d_ack}, 32'd0);
    chk("t4_d_data", cap_d_data,         32'd0);
    chk("t4_i_ack",  {31'd0, cap_i_ack}, 32'd0);
    tick();
    chk("t4_idle",   {31'd0, m_re},      32'd0);
    i_addr = 32'h500;
    i_re   = 1'b1;
    serve(1, 32'h5555_0500, 1'b0, 1'b0, 32'd0);
    chk("t4_i_ack",  {31'd0, cap_i_ack}, 32'd1);
    chk("t4_i_data", cap_i_data,         32'h5555_0500);
    chk("t4_m_addr", cap_addr,           32'h500);
    i_re = 1'b0;
    tick();

    // Reset during BUSY_I, then a stray m_ack
    i_addr = 32'h600;
    i_re   = 1'b1;
    wait_cyc = 0;
    while (m_re !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    chk("t5_busy", {31'd0, m_re}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_m_re_async",   {31'd0, m_re}, 32'd0);
    chk("t5_m_addr_async", m_addr,        32'd0);
    i_re = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    m_ack  = 1'b1;
    m_data = 32'hFFFF_0000;
    #1;
    chk("t5_stray_i_ack",  {31'd0, i_ack}, 32'd0);
    chk("t5_stray_d_ack",  {31'd0, d_ack}, 32'd0);
    chk("t5_stray_i_data", i_data,         32'd0);
    tick();
    m_ack  = 1'b0;
    m_data = '0;
    tick();

    // Back-to-back instruction reads with 1-cycle memory ack
    i_addr = 32'h700;
    i_re   = 1'b1;
    serve(1, 32'h0000_0007, 1'b0, 1'b1, 32'h704);
    chk("t6a_m_addr", cap_addr,           32'h700);
    chk("t6a_i_ack",  {31'd0, cap_i_ack}, 32'd1);
    chk("t6a_gap",    {31'd0, m_re},      32'd0);
    chk("t6a_hold",   m_addr,             32'h700);
    serve(1, 32'h0000_0008, 1'b0, 1'b1, 32'h708);
    chk("t6b_m_addr", cap_addr,           32'h704);
    chk("t6b_i_data", cap_i_data,         32'h0000_0008);
    chk("t6b_gap",    {31'd0, m_re},      32'd0);
    i_re = 1'b0;
    tick();
    tick();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
